note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Controller that owns the note code and beat strobe feeding the square-wave tone generator ({med,low} note code, beat-latched).
Shares the generator between two requesters: the live keyboard and an autoplay song stored in an external synchronous ROM.
Live key presses preempt the song. The song pauses, holding its position, and resumes on key release.
Sits between the keyboard decoder / song ROM and the tone generator, all in the clk_5m domain.

Parameters:
BEAT_DIV, 1250000, clk_5m cycles per beat tick (0.25 s at 5 MHz); must be at least 4.
ADDR_W, 6, song ROM address width (64 entries).

Ports:
clk_5m  in  1  system clock, 5 MHz
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = live-only, 1 = song enabled
start  in  1  level; rising edge (sampled) starts song from address 0 when mode=1
key_valid  in  1  a key is held
key_code  in  8  {med[3:0],low[3:0]} of held key
rom_addr  out  ADDR_W  song ROM address
rom_data  in  11  {dur[2:0],med[3:0],low[3:0]}; valid 1 cycle after rom_addr
med  out  4  note code to tone generator, middle octave
low  out  4  note code to tone generator, low octave
beat  out  1  one-cycle latch strobe to tone generator
busy  out  1  song in progress (including paused)
song_done  out  1  one-cycle pulse when end marker reached

Behaviour:
- Reset (async, rst_n=0): med=0, low=0, beat=0, rom_addr=0, busy=0, song_done=0, FSM=IDLE, beat counter=0, dur counter=0.
- Beat counter:
  - free-runs 0..BEAT_DIV-1;
  - tick = 1 for one cycle when count == BEAT_DIV-1, then wraps to 0;
  - cleared to 0 on a start edge.
- Legal codes: {0,1..7} low octave, {1..7,0} middle octave, 8'h00 = rest.
  - Any other code (both nibbles nonzero, or a nibble > 7) is driven as 8'h00.
  - Exception: 8'hFF in the ROM is the end marker.
- Song entry duration: dur d lasts d+1 beat ticks.
- FSM states:
  - IDLE: busy=0. A start rising edge with mode=1 sets rom_addr=0 and goes to FETCH.
  - FETCH: waits 1 cycle for ROM latency, then goes to LOAD.
  - LOAD:
    - if note code == 8'hFF, pulse song_done and go to IDLE;
    - else latch the song note and dur, rom_addr += 1 (wraps modulo 2^ADDR_W), go to PLAY.
  - PLAY:
    - dur counter decrements on each tick;
    - on the tick where the counter is 0, go to FETCH;
    - the next note is therefore loaded within 2 cycles after that tick.
  - PAUSE:
    - entered from PLAY or FETCH when key_valid=1;
    - dur counter and rom_addr frozen;
    - key_valid=0 returns to the suspended state.
- Any state: mode=0 forces IDLE with busy=0, no song_done pulse; the rom_addr value is don't-care.
- Output code selection, registered:
  - key_valid=1: key_code, legalised;
  - else if state is PLAY, PAUSE-resumed or FETCH: the latched song note;
  - else: 8'h00.
- Beat strobe:
  - beat=1 exactly one cycle after any cycle in which the {med,low} register changed, or in which tick=1;
  - the code is therefore stable for at least 1 cycle before each beat rising edge;
  - change and tick in the same cycle produce a single pulse.
- Simultaneous events:
  - start edge while busy restarts from address 0;
  - key press in the same cycle as a LOAD: LOAD completes, then PAUSE.
- Reset mid-song: returns to IDLE immediately; the song is not resumed.

Decomposition:
- Shared package: note code constants (REST=8'h00, END_MARK=8'hFF, LOW1..LOW7, MED1..MED7), FSM state encoding (IDLE, FETCH, LOAD, PLAY, PAUSE), field offsets of rom_data.
- One natural sub-module: beat_tick_gen (counter plus tick, with synchronous clear), reused by other timing blocks.

Test Plan:
All tests use BEAT_DIV=8.
1. Release reset, no input -> med=low=0, beat pulses every 8 cycles, busy=0.
2. mode=0, key_code=8'h05 held, then released -> {med,low}=05 within 1 cycle; beat 1 cycle later; 8'h00 after release, with a beat.
3. mode=1, start; ROM = {dur2,8'h10},{dur0,8'h30},8'hFF:
   - 10 lasts 3 ticks, 30 lasts 1 tick;
   - song_done pulses once, busy drops, output 00.
4. During a dur=3 note after 1 tick, key 8'h06 held for 20 cycles -> output 06; rom_addr frozen; on release the song note resumes with 3 ticks remaining.
5. Illegal key_code 8'h48 and ROM entry 8'h9F -> driven as 8'h00.
6. Assert rst_n=0 mid-PLAY, and separately mode=0 mid-PLAY -> all outputs reset, or IDLE with no song_done pulse.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg: note codes, FSM encoding, song ROM field layout and code legalisation.
package note_sequencer_pkg;
    localparam logic [7:0] REST     = 8'h00;
    localparam logic [7:0] END_MARK = 8'hFF;
    localparam logic [7:0] LOW1 = 8'h01, LOW2 = 8'h02, LOW3 = 8'h03, LOW4 = 8'h04;
    localparam logic [7:0] LOW5 = 8'h05, LOW6 = 8'h06, LOW7 = 8'h07;
    localparam logic [7:0] MED1 = 8'h10, MED2 = 8'h20, MED3 = 8'h30, MED4 = 8'h40;
    localparam logic [7:0] MED5 = 8'h50, MED6 = 8'h60, MED7 = 8'h70;
    localparam int LOW_LSB = 0;
    localparam int MED_LSB = 4;
    localparam int DUR_LSB = 8;
    localparam int DUR_W   = 3;

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_PLAY, ST_PAUSE} state_t;

    function automatic logic [7:0] legalise(input logic [7:0] c);
        return (c inside {REST, LOW1, LOW2, LOW3, LOW4, LOW5, LOW6, LOW7,
                          MED1, MED2, MED3, MED4, MED5, MED6, MED7}) ? c : REST;
    endfunction
endpackage

// File: rtl/note_sequencer_beat_tick_gen.sv
// beat_tick_gen: free-running 0..DIV-1 counter with a one-cycle tick at DIV-1 and synchronous clear.
module beat_tick_gen #(
    parameter int DIV = 1250000
) (
    input  logic clk_5m,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] count_q, count_d;

    assign tick = count_q == CW'(DIV - 1);

    always_comb count_d = (clr || tick) ? '0 : count_q + CW'(1);

    always_ff @(posedge clk_5m or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: arbitrates live keys and a ROM-driven song onto the tone generator's note code and beat strobe.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int BEAT_DIV = 1250000,
    parameter int ADDR_W   = 6
) (
    input  logic              clk_5m,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              start,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [10:0]       rom_data,
    output logic [3:0]        med,
    output logic [3:0]        low,
    output logic              beat,
    output logic              busy,
    output logic              song_done
);
    state_t            state_q, state_d, resume_q, resume_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        note_q, note_d, code_q, code_d, code_prev_q;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              beat_q, beat_d, done_q, done_d, start_q;
    logic              start_go, tick;
    logic [7:0]        rom_note;

    assign rom_note = rom_data[LOW_LSB +: 8];
    assign start_go = mode && start && !start_q;

    beat_tick_gen #(.DIV(BEAT_DIV)) u_tick (
        .clk_5m (clk_5m),
        .rst_n  (rst_n),
        .clr    (start_go),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        dur_d      = dur_q;
        done_d     = 1'b0;
        if (!mode) begin
            state_d = ST_IDLE;
        end else if (start_go) begin
            state_d    = ST_FETCH;
            rom_addr_d = '0;
            note_d     = REST;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_FETCH: begin
                    resume_d = key_valid ? ST_FETCH : resume_q;
                    state_d  = key_valid ? ST_PAUSE : ST_LOAD;
                end
                ST_LOAD: begin
                    if (rom_note == END_MARK) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        note_d     = legalise(rom_note);
                        dur_d      = rom_data[DUR_LSB +: DUR_W];
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (key_valid) begin
                        resume_d = ST_PLAY;
                        state_d  = ST_PAUSE;
                    end else if (tick) begin
                        state_d = (dur_q == '0) ? ST_FETCH : ST_PLAY;
                        dur_d   = (dur_q == '0) ? dur_q : dur_q - DUR_W'(1);
                    end
                end
                ST_PAUSE: state_d = key_valid ? ST_PAUSE : resume_q;
                default:  state_d = ST_IDLE;
            endcase
        end
        // LOAD keeps showing the previous note so note boundaries never flash a rest
        code_d = key_valid ? legalise(key_code) : (mode && state_q != ST_IDLE) ? note_q : REST;
        beat_d = tick || (code_q != code_prev_q);
    end

    always_ff @(posedge clk_5m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            resume_q    <= ST_IDLE;
            rom_addr_q  <= '0;
            note_q      <= REST;
            dur_q       <= '0;
            code_q      <= REST;
            code_prev_q <= REST;
            beat_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            rom_addr_q  <= rom_addr_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            code_q      <= code_d;
            code_prev_q <= code_q;
            beat_q      <= beat_d;
            done_q      <= done_d;
            start_q     <= start;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign med       = code_q[MED_LSB +: 4];
    assign low       = code_q[LOW_LSB +: 4];
    assign beat      = beat_q;
    assign busy      = state_q != ST_IDLE;
    assign song_done = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer with BEAT_DIV=8 and a behavioural synchronous song ROM.
module tb_note_sequencer;
    logic        clk_5m = 1'b0, rst_n = 1'b0, mode = 1'b0, start = 1'b0, key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [5:0]  rom_addr;
    logic [10:0] rom_data;
    logic [3:0]  med, low;
    logic        beat, busy, song_done;
    logic [7:0]  code;
    logic [10:0] rom [64];
    int          checks = 0, passed = 0, dones;

    assign code = {med, low};

    always #5 clk_5m = ~clk_5m;

    always @(posedge clk_5m) rom_data <= rom[rom_addr];

    note_sequencer #(.BEAT_DIV(8), .ADDR_W(6)) dut (
        .clk_5m    (clk_5m),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .key_valid (key_valid),
        .key_code  (key_code),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .med       (med),
        .low       (low),
        .beat      (beat),
        .busy      (busy),
        .song_done (song_done)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_5m);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; mode = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        cyc(2);
        rst_n = 1'b1;
    endtask

    // returns just after the edge that accepts the start
    task automatic start_song;
        mode = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 11'h0FF;
        cyc(2);
        chk("rst_code", code, 8'h00);
        chk("rst_beat", {7'd0, beat}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_done", {7'd0, song_done}, 8'h00);
        chk("rst_addr", {2'd0, rom_addr}, 8'h00);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            chk("t1_beat", {7'd0, beat}, {7'd0, k % 8 == 0});
        end
        chk("t1_busy", {7'd0, busy}, 8'h00);
        chk("t1_code", code, 8'h00);

        do_reset;
        cyc(1);
        key_valid = 1'b1; key_code = 8'h05;
        cyc(1);
        chk("t2_code", code, 8'h05);
        chk("t2_nobeat", {7'd0, beat}, 8'h00);
        cyc(1);
        chk("t2_beat", {7'd0, beat}, 8'h01);
        cyc(1);
        chk("t2_beat_end", {7'd0, beat}, 8'h00);
        key_valid = 1'b0;
        cyc(1);
        chk("t2_rel_code", code, 8'h00);
        cyc(1);
        chk("t2_rel_beat", {7'd0, beat}, 8'h01);

        do_reset;
        rom[0] = {3'd2, 8'h10}; rom[1] = {3'd0, 8'h30}; rom[2] = 11'h0FF;
        cyc(1);
        start_song;
        chk("t3_busy0", {7'd0, busy}, 8'h01);
        chk("t3_addr0", {2'd0, rom_addr}, 8'h00);
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (song_done) dones++;
            chk("t3_done", {7'd0, song_done}, {7'd0, k == 34});
            if (k == 3)  chk("t3_code10", code, 8'h10);
            if (k == 4)  chk("t3_beat_chg", {7'd0, beat}, 8'h01);
            if (k == 8)  chk("t3_beat_tick", {7'd0, beat}, 8'h01);
            if (k == 23) chk("t3_code10_end", code, 8'h10);
            if (k == 23) chk("t3_busy_mid", {7'd0, busy}, 8'h01);
            if (k == 26) chk("t3_addr2", {2'd0, rom_addr}, 8'h02);
            if (k == 26) chk("t3_code_load", code, 8'h10);
            if (k == 27) chk("t3_code30", code, 8'h30);
            if (k == 28) chk("t3_beat30", {7'd0, beat}, 8'h01);
            if (k == 34) chk("t3_busy_end", {7'd0, busy}, 8'h00);
            if (k == 35) chk("t3_code_end", code, 8'h00);
        end
        chk("t3_done_cnt", 8'(dones), 8'h01);

        do_reset;
        rom[0] = {3'd3, 8'h20}; rom[1] = 11'h0FF;
        cyc(1);
        start_song;
        for (int k = 1; k <= 52; k++) begin
            cyc(1);
            if (k == 11) chk("t4_key", code, 8'h06);
            if (k == 12) chk("t4_key_beat", {7'd0, beat}, 8'h01);
            if (k == 20) chk("t4_addr_frz", {2'd0, rom_addr}, 8'h01);
            if (k == 20) chk("t4_busy", {7'd0, busy}, 8'h01);
            if (k == 20) chk("t4_key_hold", code, 8'h06);
            if (k == 31) chk("t4_resume", code, 8'h20);
            if (k == 47) chk("t4_last_tick", code, 8'h20);
            if (k == 47) chk("t4_busy_late", {7'd0, busy}, 8'h01);
            if (k == 48) chk("t4_fetch_code", code, 8'h20);
            if (k == 50) chk("t4_done", {7'd0, song_done}, 8'h01);
            if (k == 50) chk("t4_idle", {7'd0, busy}, 8'h00);
            if (k == 51) chk("t4_rest", code, 8'h00);
            if (k == 10) begin key_valid = 1'b1; key_code = 8'h06; end
            if (k == 30) key_valid = 1'b0;
        end

        do_reset;
        cyc(1);
        key_valid = 1'b1; key_code = 8'h48;
        cyc(1);
        chk("t5_key48", code, 8'h00);
        cyc(1);
        chk("t5_nobeat", {7'd0, beat}, 8'h00);
        key_code = 8'h70;
        cyc(1);
        chk("t5_key70", code, 8'h70);
        key_code = 8'h08;
        cyc(1);
        chk("t5_key08", code, 8'h00);
        key_valid = 1'b0;
        do_reset;
        rom[0] = {3'd1, 8'h9F}; rom[1] = 11'h0FF;
        cyc(1);
        start_song;
        cyc(3);
        chk("t5_rom9f", code, 8'h00);
        chk("t5_busy", {7'd0, busy}, 8'h01);
        cyc(5);
        chk("t5_rom9f_late", code, 8'h00);
        chk("t5_addr1", {2'd0, rom_addr}, 8'h01);

        do_reset;
        rom[0] = {3'd2, 8'h10}; rom[1] = 11'h0FF;
        cyc(1);
        start_song;
        cyc(5);
        chk("t6_play", code, 8'h10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_code", code, 8'h00);
        chk("t6_rst_busy", {7'd0, busy}, 8'h00);
        chk("t6_rst_addr", {2'd0, rom_addr}, 8'h00);
        chk("t6_rst_beat", {7'd0, beat}, 8'h00);
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        chk("t6_no_resume", {7'd0, busy}, 8'h00);
        chk("t6_no_resume_code", code, 8'h00);

        do_reset;
        cyc(1);
        start_song;
        cyc(5);
        chk("t6m_play", code, 8'h10);
        mode = 1'b0;
        for (int k = 6; k <= 15; k++) begin
            cyc(1);
            chk("t6m_nodone", {7'd0, song_done}, 8'h00);
            if (k == 6) chk("t6m_busy", {7'd0, busy}, 8'h00);
            if (k == 6) chk("t6m_code", code, 8'h00);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
